booth_seq_mult: RTL and testbench

Sequential radix-4 Booth multiplier, parametrised in operand width, with a start/busy/done handshake and a per-operation signed/unsigned mode. It follows the single-cycle combinational 32×32 Booth array as its area-reduced successor: one radix-4 digit is retired per clock, so a WIDTH×WIDTH product completes in WIDTH/2+1 cycles. It sits behind a datapath or CPU execute stage that can tolerate multi-cycle multiply latency.

---
 rtl/booth_seq_mult.sv | 137 +++++++++++++
 tb/tb_booth_seq_mult.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Digits cover the operand extended by two bits, so every input in both
    // modes is a valid (WIDTH+2)-bit two's-complement number.
    localparam int N    = WIDTH / 2 + 1;
    localparam int BW   = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CW   = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last_digit;

    logic [ACCW-1:0]   acc;
    logic [ACCW-1:0]   mcand;
    logic [BW-1:0]     mq;
    logic              mq_prev;
    logic [CW-1:0]     cnt;

    logic [ACCW-1:0]   a_ext;
    logic [BW-1:0]     b_ext;
    logic [ACCW-1:0]   term;
    logic [ACCW-1:0]   sum;

    // Unsigned operands are zero-extended, signed ones sign-extended; the
    // multiplicand goes straight to accumulator width since it is shifted up.
    assign a_ext = {{(ACCW-WIDTH){a[WIDTH-1] & signed_mode}}, a};
    assign b_ext = {{2{b[WIDTH-1] & signed_mode}}, b};

    assign last_digit = (cnt == CW'(N - 1));

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, accept decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth digit select from the multiplier triplet {b[2i+1], b[2i], b[2i-1]};
    // mcand already carries the 4^i weight.
    always_comb begin
        term = '0;
        case ({mq[1:0], mq_prev})
            3'b001, 3'b010: term = mcand;
            3'b011:         term = mcand << 1;
            3'b100:         term = -(mcand << 1);
            3'b101, 3'b110: term = -mcand;
            default:        term = '0;
        endcase
    end

    assign sum = acc + term;

    // Operand capture, per-digit accumulate/shift, and result write on the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mq      <= '0;
            mq_prev <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            acc     <= '0;
            mcand   <= a_ext;
            mq      <= b_ext;
            mq_prev <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            acc     <= sum;
            mcand   <= mcand << 2;
            mq      <= {2'b00, mq[BW-1:2]};
            mq_prev <= mq[1];
            cnt     <= cnt + CW'(1);
            if (last_digit) begin
                result <= sum[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - scoreboard bench for booth_seq_mult at WIDTH 32 and 8
module tb_booth_seq_mult;

    localparam int N32 = 17;
    localparam int N8  = 5;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start32, sm32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] res32;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    booth_seq_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .signed_mode(sm32), .busy(busy32), .done(done32), .result(res32)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .result(res8)
    );

    typedef struct {
        logic [63:0] exp;
        int          acc;
    } item_t;

    item_t       q32[$];
    item_t       q8[$];
    item_t       it32, it8;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    logic [63:0] last32 = '0;
    logic [15:0] last8 = '0;
    int          brun32 = 0;
    int          brun8 = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint            xs, ys;
        longint unsigned   xu, yu;
        if (s) begin
            xs = longint'($signed(x));
            ys = longint'($signed(y));
            return 64'(xs * ys);
        end
        xu = 64'(x);
        yu = 64'(y);
        return xu * yu;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'({24'd0, x}) * int'({24'd0, y});
        return p[15:0];
    endfunction

    // Monitor for the 32-bit instance: result, latency, hold and busy length.
    always @(negedge clk) begin
        if (rst) begin
            brun32 = 0;
            last32 = '0;
        end else begin
            if (done32) begin
                if (q32.size() == 0) begin
                    check("done32_without_request", 64'(q32.size()), 64'd1);
                end else begin
                    it32 = q32.pop_front();
                    check("result32", res32, it32.exp);
                    check("latency32", 64'(cyc - it32.acc), 64'(N32));
                    last32 = it32.exp;
                end
            end else begin
                check("hold32", res32, last32);
            end
            if (busy32) brun32++;
            else if (brun32 != 0) begin
                check("busy_len32", 64'(brun32), 64'(N32));
                brun32 = 0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            brun8 = 0;
            last8 = '0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    check("done8_without_request", 64'(q8.size()), 64'd1);
                end else begin
                    it8 = q8.pop_front();
                    check("result8", 64'(res8), it8.exp);
                    check("latency8", 64'(cyc - it8.acc), 64'(N8));
                    last8 = it8.exp[15:0];
                end
            end else begin
                check("hold8", 64'(res8), 64'(last8));
            end
            if (busy8) brun8++;
            else if (brun8 != 0) begin
                check("busy_len8", 64'(brun8), 64'(N8));
                brun8 = 0;
            end
        end
    end

    task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic s, input logic [63:0] exp);
        int k = 0;
        while (busy32 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy32) check("issue32_busy_timeout", 64'(busy32), 64'd0);
        a32 = av; b32 = bv; sm32 = s; start32 = 1'b1;
        q32.push_back(item_t'{exp, cyc + 1});
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s);
        int k = 0;
        while (busy8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy8) check("issue8_busy_timeout", 64'(busy8), 64'd0);
        a8 = av; b8 = bv; sm8 = s; start8 = 1'b1;
        q8.push_back(item_t'{64'(ref8(av, bv, s)), cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done32(output int t);
        int k = 0;
        while (!done32 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done32) check("done32_timeout", 64'(done32), 64'd1);
        t = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, k;
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1;
        start32 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0;
        start8 = 1'b0;  a8 = '0;  b8 = '0;  sm8 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy32", 64'(busy32), 64'd0);
        check("reset_done32", 64'(done32), 64'd0);
        check("reset_result32", res32, 64'd0);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_result8", 64'(res8), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue32(32'd50, 32'hFFFF_FFD8, 1'b1, 64'hFFFF_FFFF_FFFF_F830);
        issue32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue32(32'hFFFF_FC19, 32'd999, 1'b1, 64'hFFFF_FFFF_FFF0_C58F);
        issue32(32'd98765, 32'd0, 1'b1, 64'd0);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        wait_done32(t0);

        issue32(32'hFFFF_FFB0, 32'hFFFF_FFBF, 1'b1, 64'd5200);
        repeat (5) @(negedge clk);
        start32 = 1'b1; a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        start32 = 1'b0;
        wait_done32(t1);
        issue32(32'd90, 32'd70, 1'b1, 64'd6300);
        wait_done32(t2);
        check("b2b_spacing", 64'(t2 - t1), 64'd18);

        @(negedge clk);
        issue32(32'hFFFF_FE0C, 32'd2000, 1'b1, 64'hFFFF_FFFF_FFF0_BDC0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy32", 64'(busy32), 64'd0);
        check("async_rst_done32", 64'(done32), 64'd0);
        check("async_rst_result32", res32, 64'd0);
        q32.delete();
        @(posedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        issue32(32'hFFFF_FFF6, 32'd325, 1'b1, 64'hFFFF_FFFF_FFFF_F34E);
        wait_done32(t0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            issue32(ra, rb, rs, ref32(ra, rb, rs));
        end

        for (int i = 0; i < 1000; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'(i % 2));
        end

        k = 0;
        while ((q32.size() != 0 || q8.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
